// File: rtl/ex_stage_if.sv
// Signal bundle between the controller/decode side (master) and the execute stage (slave).
interface ex_stage_if #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76
);
  logic [5:0]              stall;
  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [37:0]             ex_to_rf_bus;
  logic                    ex_is_load;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;
  logic                    stallreq_for_ex;

  modport master (
    output stall, id_to_ex_bus,
    input  ex_to_mem_bus, ex_to_rf_bus, ex_is_load, data_sram_en, data_sram_wen,
           data_sram_addr, data_sram_wdata, stallreq_for_ex
  );

  modport slave (
    input  stall, id_to_ex_bus,
    output ex_to_mem_bus, ex_to_rf_bus, ex_is_load, data_sram_en, data_sram_wen,
           data_sram_addr, data_sram_wdata, stallreq_for_ex
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, ALU, data-SRAM request, HI/LO with
// single-cycle multiply and a multi-cycle restoring divider.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int DIV_CYCLES   = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_stage_if.slave  io
);
  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} div_state_t;

  function automatic logic [31:0] f_mag(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] f_neg_if(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  logic w_bubble, w_load;
  assign w_bubble = io.stall[2] & ~io.stall[3];
  assign w_load   = ~io.stall[2];

  // ---- ID/EX pipeline register ----
  logic [ID_TO_EX_WD-1:0] r_id_ex_p0;
  always_ff @(posedge clk) begin
    if (rst)           r_id_ex_p0 <= '0;
    else if (w_bubble) r_id_ex_p0 <= '0;
    else if (w_load)   r_id_ex_p0 <= io.id_to_ex_bus;
  end

  logic [31:0] w_pc, w_inst, w_rdata1, w_rdata2;
  logic [11:0] w_alu_op;
  logic [2:0]  w_sel_src1;
  logic [3:0]  w_sel_src2, w_ram_wen;
  logic        w_ram_en, w_rf_we, w_sel_rf_res;
  logic [4:0]  w_rf_waddr;
  assign {w_pc, w_inst, w_alu_op, w_sel_src1, w_sel_src2, w_ram_en, w_ram_wen,
          w_rf_we, w_rf_waddr, w_sel_rf_res, w_rdata1, w_rdata2} = r_id_ex_p0;

  logic       w_special;
  logic [5:0] w_func;
  assign w_special = (w_inst[31:26] == 6'h00);
  assign w_func    = w_inst[5:0];

  logic w_is_mfhi, w_is_mflo, w_is_mthi, w_is_mtlo, w_is_mult, w_is_multu, w_is_div, w_is_divu;
  assign w_is_mfhi  = w_special && (w_func == 6'h10);
  assign w_is_mthi  = w_special && (w_func == 6'h11);
  assign w_is_mflo  = w_special && (w_func == 6'h12);
  assign w_is_mtlo  = w_special && (w_func == 6'h13);
  assign w_is_mult  = w_special && (w_func == 6'h18);
  assign w_is_multu = w_special && (w_func == 6'h19);
  assign w_is_div   = w_special && (w_func == 6'h1A);
  assign w_is_divu  = w_special && (w_func == 6'h1B);

  logic signed [31:0] w_imm_sext, w_src1, w_src2, w_alu_res;
  assign w_imm_sext = {{16{w_inst[15]}}, w_inst[15:0]};

  always_comb begin
    w_src1 = '0;
    if (w_sel_src1[0])      w_src1 = w_rdata1;
    else if (w_sel_src1[1]) w_src1 = w_pc;
    else if (w_sel_src1[2]) w_src1 = {27'b0, w_inst[10:6]};
  end

  always_comb begin
    w_src2 = '0;
    if (w_sel_src2[0])      w_src2 = w_rdata2;
    else if (w_sel_src2[1]) w_src2 = w_imm_sext;
    else if (w_sel_src2[2]) w_src2 = 32'sd8;
    else if (w_sel_src2[3]) w_src2 = {16'b0, w_inst[15:0]};
  end

  always_comb begin
    w_alu_res = '0;
    if (w_alu_op[11])     w_alu_res = w_src1 + w_src2;
    else if (w_alu_op[10]) w_alu_res = w_src1 - w_src2;
    else if (w_alu_op[9])  w_alu_res = {31'b0, (w_src1 < w_src2)};
    else if (w_alu_op[8])  w_alu_res = {31'b0, ($unsigned(w_src1) < $unsigned(w_src2))};
    else if (w_alu_op[7])  w_alu_res = w_src1 & w_src2;
    else if (w_alu_op[6])  w_alu_res = ~(w_src1 | w_src2);
    else if (w_alu_op[5])  w_alu_res = w_src1 | w_src2;
    else if (w_alu_op[4])  w_alu_res = w_src1 ^ w_src2;
    else if (w_alu_op[3])  w_alu_res = w_src2 << w_src1[4:0];
    else if (w_alu_op[2])  w_alu_res = $signed($unsigned(w_src2) >> w_src1[4:0]);
    else if (w_alu_op[1])  w_alu_res = w_src2 >>> w_src1[4:0];
    else if (w_alu_op[0])  w_alu_res = {w_src2[15:0], 16'b0};
  end

  logic [31:0] r_hi, r_lo, w_result;
  assign w_result = w_is_mfhi ? r_hi : (w_is_mflo ? r_lo : $unsigned(w_alu_res));

  assign io.ex_to_mem_bus   = {w_pc, w_ram_en, w_ram_wen, w_sel_rf_res, w_rf_we, w_rf_waddr, w_result};
  assign io.ex_to_rf_bus    = {w_rf_we & ~w_sel_rf_res, w_rf_waddr, w_result};
  assign io.ex_is_load      = w_sel_rf_res;
  assign io.data_sram_en    = w_ram_en;
  assign io.data_sram_wen   = w_ram_wen;
  assign io.data_sram_addr  = w_rdata1 + $unsigned(w_imm_sext);
  assign io.data_sram_wdata = w_rdata2;

  // ---- divider ----
  div_state_t       r_state, w_state_nxt;
  logic             r_done_flag, w_div_start, w_div_commit, w_stallreq;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_divisor, r_rem, r_quo;
  logic             r_q_neg, r_r_neg, r_div_zero;

  always_comb begin
    w_state_nxt = r_state;
    w_div_start = 1'b0;
    w_stallreq  = 1'b0;
    unique case (r_state)
      S_IDLE: if ((w_is_div || w_is_divu) && !r_done_flag) begin
        w_stallreq  = 1'b1;
        w_div_start = 1'b1;
        w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        w_stallreq = 1'b1;
        if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
      end
      S_DONE:  if (w_load || w_bubble) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_div_commit       = (r_state == S_DONE) && !io.stall[3] && !r_done_flag;
  assign io.stallreq_for_ex = w_stallreq;

  // Remainder stays below the divisor, so 33 bits hold the shifted trial value.
  logic [32:0] w_shift, w_trial;
  assign w_shift = {r_rem, r_quo[31]};
  assign w_trial = w_shift - {1'b0, r_divisor};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_done_flag <= 1'b0;
      r_cnt       <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load || w_bubble) r_done_flag <= 1'b0;
      else if (w_div_commit)  r_done_flag <= 1'b1;
      if (w_div_start) begin
        r_cnt      <= '0;
        r_rem      <= '0;
        r_quo      <= f_mag(w_rdata1, w_is_div);
        r_divisor  <= f_mag(w_rdata2, w_is_div);
        r_q_neg    <= w_is_div & (w_rdata1[31] ^ w_rdata2[31]);
        r_r_neg    <= w_is_div & w_rdata1[31];
        r_div_zero <= (w_rdata2 == 32'd0);
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_rem <= w_trial[32] ? w_shift[31:0] : w_trial[31:0];
        r_quo <= {r_quo[30:0], ~w_trial[32]};
      end
    end
  end

  logic signed [63:0] w_prod_s;
  logic        [63:0] w_prod_u;
  assign w_prod_s = $signed(w_rdata1) * $signed(w_rdata2);
  assign w_prod_u = {32'b0, w_rdata1} * {32'b0, w_rdata2};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_div_commit) begin
      r_hi <= f_neg_if(r_rem, r_r_neg);
      r_lo <= r_div_zero ? 32'hFFFF_FFFF : f_neg_if(r_quo, r_q_neg);
    end else if (!io.stall[3]) begin
      if (w_is_mthi)  r_hi <= w_rdata1;
      if (w_is_mtlo)  r_lo <= w_rdata1;
      if (w_is_mult)  {r_hi, r_lo} <= $unsigned(w_prod_s);
      if (w_is_multu) {r_hi, r_lo} <= w_prod_u;
    end
  end

  logic w_unused;
  assign w_unused = ^{io.stall[5:4], io.stall[1:0], w_inst[25:16]};
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: vector table, randomized ALU/mult/div against a plain-arithmetic model.
module tb_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_stage_if #(.ID_TO_EX_WD(159), .EX_TO_MEM_WD(76)) io();
  ex_stage dut (.clk(clk), .rst(rst), .io(io));

  int errors = 0;
  int checks = 0;

  localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200, OP_SLTU = 12'h100,
                          OP_NOR = 12'h040, OP_SLL = 12'h008, OP_SRA = 12'h002, OP_LUI = 12'h001;

  typedef struct {
    string       name;
    logic [31:0] pc, inst;
    logic [11:0] op;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic        ren;
    logic [3:0]  wen;
    logic        we;
    logic [4:0]  wa;
    logic        lr;
    logic [31:0] r1, r2, exp_res;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [158:0] mk(input logic [31:0] pc, inst, input logic [11:0] op,
      input logic [2:0] s1, input logic [3:0] s2, input logic ren, input logic [3:0] wen,
      input logic we, input logic [4:0] wa, input logic lr, input logic [31:0] r1, r2);
    return {pc, inst, op, s1, s2, ren, wen, we, wa, lr, r1, r2};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] opc, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rs, rt, rd, sa, input logic [5:0] func);
    return {6'h00, rs, rt, rd, sa, func};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [158:0] bus);
    io.stall = 6'b0;
    io.id_to_ex_bus = bus;
    step();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".mem"}, io.ex_to_mem_bus, 0);
    chk({name, ".rf"}, io.ex_to_rf_bus, 0);
    chk({name, ".sram"}, {io.data_sram_en, io.data_sram_wen, io.data_sram_addr, io.data_sram_wdata}, 0);
    chk({name, ".stallreq"}, io.stallreq_for_ex, 0);
  endtask

  // Reads HI then LO through mfhi/mflo and compares against expectations.
  task automatic chk_hilo(input string name, input logic [31:0] hi, lo);
    issue(mk(32'h0, mk_r(0, 0, 5'd9, 0, 6'h10), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0, 0, 0));
    chk({name, ".hi"}, io.ex_to_mem_bus[31:0], hi);
    issue(mk(32'h0, mk_r(0, 0, 5'd9, 0, 6'h12), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0, 0, 0));
    chk({name, ".lo"}, io.ex_to_mem_bus[31:0], lo);
  endtask

  // Issues a div/divu, stalls while requested, then checks stall length and HI/LO.
  task automatic run_div(input string name, input logic is_signed, input logic [31:0] a, b,
                         input logic [31:0] hi, lo);
    int cnt = 0;
    issue(mk(32'h0, mk_r(5'd1, 5'd2, 0, 0, is_signed ? 6'h1A : 6'h1B), 12'h0, 3'b0, 4'b0,
             1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b));
    io.id_to_ex_bus = '0;
    while (io.stallreq_for_ex && cnt < 100) begin
      io.stall = 6'b001111;
      cnt++;
      step();
    end
    io.stall = 6'b0;
    chk({name, ".stall_cycles"}, cnt, 33);
    issue(mk(32'h0, mk_r(0, 0, 5'd9, 0, 6'h10), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0, 0, 0));
    chk({name, ".next_stallreq"}, io.stallreq_for_ex, 0);
    chk({name, ".hi"}, io.ex_to_mem_bus[31:0], hi);
    issue(mk(32'h0, mk_r(0, 0, 5'd9, 0, 6'h12), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b1, 5'd9, 1'b0, 0, 0));
    chk({name, ".lo"}, io.ex_to_mem_bus[31:0], lo);
  endtask

  function automatic logic [31:0] model_alu(input int k, input logic [31:0] a, b);
    case (k)
      0:  return a + b;
      1:  return a - b;
      2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return b << a[4:0];
      9:  return b >> a[4:0];
      10: return 32'($signed(b) >>> a[4:0]);
      default: return {b[15:0], 16'h0};
    endcase
  endfunction

  vec_t vecs[10];

  initial begin
    io.stall = 6'b0;
    io.id_to_ex_bus = mk(32'hBFC0_0000, mk_i(6'h09, 1, 2, 16'h0001), OP_ADD, 3'b001, 4'b0010,
                         1'b1, 4'hF, 1'b1, 5'd2, 1'b0, 32'h55, 32'hAA);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all_zero($sformatf("reset%0d", i));
    end
    rst = 1'b0;

    vecs[0] = '{"addiu", 32'h0, mk_i(6'h09, 1, 2, 16'hFFFF), OP_ADD, 3'b001, 4'b0010, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'd5, 32'd0, 32'd4};
    vecs[1] = '{"sll", 32'h0, mk_r(0, 3, 4, 4, 6'h00), OP_SLL, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd0, 32'hF, 32'hF0};
    vecs[2] = '{"lui", 32'h0, mk_i(6'h0F, 0, 5, 16'h1234), OP_LUI, 3'b000, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'd0, 32'd0, 32'h1234_0000};
    vecs[3] = '{"sltu", 32'h0, mk_r(1, 2, 3, 0, 6'h2B), OP_SLTU, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd1};
    vecs[4] = '{"sw", 32'h0, mk_i(6'h2B, 1, 2, 16'hFFFC), OP_ADD, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h100, 32'hDEAD_BEEF, 32'hFC};
    vecs[5] = '{"lw", 32'h0, mk_i(6'h23, 1, 8, 16'h0004), OP_ADD, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd8, 1'b1, 32'h200, 32'h0, 32'h204};
    vecs[6] = '{"slt", 32'h0, mk_r(1, 2, 3, 0, 6'h2A), OP_SLT, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1};
    vecs[7] = '{"sra", 32'h0, mk_r(0, 2, 3, 4, 6'h03), OP_SRA, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd0, 32'h8000_0000, 32'hF800_0000};
    vecs[8] = '{"sub", 32'h0, mk_r(1, 2, 3, 0, 6'h23), OP_SUB, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd3, 32'd5, 32'hFFFF_FFFE};
    vecs[9] = '{"jal", 32'hBFC0_0000, {6'h03, 26'h10}, OP_ADD, 3'b010, 4'b0100, 1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'd0, 32'd0, 32'hBFC0_0008};

    for (int i = 0; i < 10; i++) begin
      vec_t v = vecs[i];
      issue(mk(v.pc, v.inst, v.op, v.s1, v.s2, v.ren, v.wen, v.we, v.wa, v.lr, v.r1, v.r2));
      chk({v.name, ".result"}, io.ex_to_mem_bus[31:0], v.exp_res);
      chk({v.name, ".pc"}, io.ex_to_mem_bus[75:44], v.pc);
      chk({v.name, ".mem_ctl"}, io.ex_to_mem_bus[43:32], {v.ren, v.wen, v.lr, v.we, v.wa});
      chk({v.name, ".fwd"}, io.ex_to_rf_bus, {v.we & ~v.lr, v.wa, v.exp_res});
      chk({v.name, ".is_load"}, io.ex_is_load, v.lr);
      chk({v.name, ".sram_ctl"}, {io.data_sram_en, io.data_sram_wen}, {v.ren, v.wen});
      chk({v.name, ".addr"}, io.data_sram_addr, v.r1 + {{16{v.inst[15]}}, v.inst[15:0]});
      chk({v.name, ".wdata"}, io.data_sram_wdata, v.r2);
    end

    for (int i = 0; i < 150; i++) begin
      int          k   = $urandom_range(0, 11);
      logic [31:0] a   = $urandom;
      logic [31:0] b   = $urandom;
      logic [15:0] imm = 16'($urandom);
      logic [31:0] exp;
      if (k == 11) b = {16'h0, imm};
      exp = model_alu(k, a, b);
      issue(mk(32'h0, mk_i(6'h08, 1, 2, imm), 12'h800 >> k, 3'b001, (k == 11) ? 4'b1000 : 4'b0001,
               1'b0, 4'h0, 1'b1, 5'd2, 1'b0, a, (k == 11) ? 32'h0 : b));
      chk($sformatf("rand_alu%0d.k%0d", i, k), io.ex_to_rf_bus, {1'b1, 5'd2, exp});
      chk($sformatf("rand_alu%0d.stallreq", i), io.stallreq_for_ex, 0);
    end

    issue(mk(32'h0, mk_r(1, 2, 0, 0, 6'h18), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
             32'hFFFF_FFFE, 32'd3));
    chk_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      logic        sg = i[0];
      logic [63:0] p;
      if (sg) p = 64'(longint'($signed(a)) * longint'($signed(b)));
      else    p = {32'h0, a} * {32'h0, b};
      issue(mk(32'h0, mk_r(1, 2, 0, 0, sg ? 6'h18 : 6'h19), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0,
               5'd0, 1'b0, a, b));
      chk_hilo($sformatf("rand_mult%0d", i), p[63:32], p[31:0]);
    end

    issue(mk(32'h1000, mk_i(6'h09, 1, 2, 16'h0010), OP_ADD, 3'b001, 4'b0010, 1'b1, 4'h3,
             1'b1, 5'd2, 1'b0, 32'h40, 32'h77));
    io.stall = 6'b000111;
    step();
    chk_all_zero("bubble");
    chk("bubble.is_load", io.ex_is_load, 0);

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div("divu_9_0", 1'b0, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
    run_div("div_m9_0", 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);

    for (int i = 0; i < 4; i++) begin
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom_range(1, 32'h0FFF_FFFF);
      logic        sg = i[0];
      longint      sa, sb, q, r;
      if (sg) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'h0, a});
        sb = longint'({32'h0, b});
      end
      q = sa / sb;
      r = sa % sb;
      run_div($sformatf("rand_div%0d", i), sg, a, b, 32'(r), 32'(q));
    end

    begin
      int cnt = 0;
      issue(mk(32'h0, mk_r(1, 2, 0, 0, 6'h1B), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
               32'd1000, 32'd3));
      while (io.stallreq_for_ex && cnt < 11) begin
        io.stall = 6'b001111;
        cnt++;
        step();
      end
      chk("rst_mid_div.busy", io.stallreq_for_ex, 1);
      rst = 1'b1;
      step();
      chk("rst_mid_div.stallreq", io.stallreq_for_ex, 0);
      rst = 1'b0;
      io.stall = 6'b0;
      chk_hilo("rst_mid_div", 32'd0, 32'd0);
      chk("rst_mid_div.after", io.stallreq_for_ex, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
